ps2_txrx_ctrl: RTL
==================

# ps2_txrx_ctrl

PS/2 host-side link controller that sequences the bidirectional PS/2 protocol on the synchronized clock/data lines. It deframes device-to-host frames (start, 8 data LSB-first, odd parity, stop), and runs the host-to-device transmit sequence: clock inhibit, request-to-send, bit shifting and acknowledge. It arbitrates the single shared link between the receive and transmit directions. It sits between the PS/2 line synchronizers/open-drain pads and the Avalon slave register file.

## Interface
- INHIBIT_CYCLES, 5000: clk cycles the PS/2 clock is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 100000: maximum clk cycles between PS/2 clock falling edges inside a frame (2 ms at 50 MHz).

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk_s  in  1  PS/2 clock, already synchronized to clk.
- ps2_data_s  in  1  PS/2 data, already synchronized to clk.
- ps2_clk_oe  out  1  1 = pad pulls PS/2 clock low; 0 = released.
- ps2_data_oe  out  1  1 = pad pulls PS/2 data low; 0 = released.
- tx_valid  in  1  transmit request; tx_data is valid.
- tx_data  in  8  byte to send to the device.
- tx_ready  out  1  request accepted when tx_valid & tx_ready.
- tx_done  out  1  one-cycle pulse at the end of a transmit attempt.
- tx_err  out  1  qualifies tx_done: no ACK or timeout.
- rx_valid  out  1  one-cycle pulse; rx_data holds the received byte.
- rx_data  out  8  last received byte; held until the next rx_valid.
- rx_err  out  1  one-cycle pulse: parity error or bad stop (together with rx_valid), or RX timeout (alone).

## Operation
- Falling-edge detect: fall = clk_prev & ~ps2_clk_s. clk_prev resets to 1.
- States: IDLE, RX, TX_INH, TX_SHIFT, TX_ACK.
- IDLE: both oe = 0.
  - A fall with ps2_data_s = 0 enters RX, with bit count 0.
  - tx_ready = (state == IDLE) & ~(fall & ~ps2_data_s). On the same cycle, an RX start wins and tx is not accepted.
  - On tx_valid & tx_ready: latch tx_data, compute parity = ~^tx_data, go to TX_INH.
- RX: each fall samples ps2_data_s.
  - Samples 1–8 form data bits 0–7, LSB first.
  - Sample 9 is the parity bit; sample 10 is the stop bit.
  - On sample 10:
    - Update rx_data.
    - Pulse rx_valid.
    - Pulse rx_err if parity is not odd or stop = 0.
    - Return to IDLE.
- TX_INH: ps2_clk_oe = 1 for INHIBIT_CYCLES cycles.
  - Then ps2_data_oe = 1 (start bit) and ps2_clk_oe = 0 in the same cycle; go to TX_SHIFT.
- TX_SHIFT: on each fall, present the next bit. ps2_data_oe = ~bit, so a 1 is released.
  - Falls 1–8 present data bits 0–7.
  - Fall 9 presents parity.
  - Fall 10 presents stop: ps2_data_oe = 0. Go to TX_ACK.
- TX_ACK: on the next fall, sample ps2_data_s.
  - Pulse tx_done.
  - tx_err = ps2_data_s, so 0 means ACK.
  - Return to IDLE.
- Timeout: a cycle counter runs in RX, TX_SHIFT and TX_ACK. It is cleared on every fall and on state entry.
  - At TIMEOUT_CYCLES: release both oe and return to IDLE.
  - In RX: pulse rx_err only (no rx_valid, rx_data unchanged).
  - In TX: pulse tx_done with tx_err = 1.
- Counter width: $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1). One counter is shared.

## Timing
- Reset values:
  - State IDLE.
  - ps2_clk_oe = ps2_data_oe = 0.
  - tx_ready = 1 (combinational from IDLE).
  - tx_done = tx_err = rx_valid = rx_err = 0.
  - rx_data = 8'h00.
- Reset asserted mid-frame releases both lines immediately (asynchronous). No done/valid pulse is produced.
- All outputs except tx_ready are registered.
- rx_valid, rx_err and updated rx_data appear 1 cycle after the clk edge that detects the stop-bit fall.
- tx_done/tx_err appear 1 cycle after the ACK fall. The state is IDLE and tx_ready = 1 in the same cycle as tx_done.
- ps2_clk_oe rises 1 cycle after acceptance and stays high exactly INHIBIT_CYCLES cycles.
- ps2_data_oe changes 1 cycle after each detected fall.
- Device-initiated falls during TX_INH are ignored.
- Pulses last exactly 1 cycle.

## Test plan
- RX 0x1C with parity 0 and stop 1 at 10 kHz PS/2 clock -> one rx_valid pulse, rx_data = 8'h1C, rx_err = 0.
- RX 0x1C with parity 1 -> rx_valid and rx_err pulse together, rx_data = 8'h1C.
- RX start plus 3 bits, then the clock stops -> after TIMEOUT_CYCLES, rx_err pulses alone, rx_data keeps its prior value, state returns to IDLE.
- TX 0xED with a device model that clocks and ACKs:
  - ps2_clk_oe is high for 5000 cycles.
  - Data bits on the line are 1,0,1,1,0,1,1,1, then parity 1, then stop released.
  - tx_done pulses with tx_err = 0.
- TX 0xFF with the device not pulling ACK -> parity bit 1 on the line, tx_done pulses with tx_err = 1.
- tx_valid asserted in the same cycle as an RX start fall -> tx_ready = 0, the RX frame completes, then the TX is accepted. Separately, reset_n is pulsed low mid-TX -> both oe = 0 at once and no tx_done.

Source files
------------

// File: rtl/ps2_txrx_ctrl.sv
// rtl/ps2_txrx_ctrl.sv - PS/2 host-side link controller (RX deframer, TX sequencer, link arbiter)
//
// Ports:
//   clk, reset_n              system clock, asynchronous active-low reset
//   ps2_clk_s, ps2_data_s     PS/2 clock/data lines, already synchronized to clk
//   ps2_clk_oe, ps2_data_oe   1 = pad pulls the line low, 0 = released
//   tx_valid/tx_data/tx_ready byte-to-device request handshake
//   tx_done/tx_err            end-of-transmit pulse, tx_err = no ACK or timeout
//   rx_valid/rx_data/rx_err   received byte pulse, held byte, parity/stop/timeout error pulse

module ps2_txrx_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_s,
  input  logic       ps2_data_s,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_TX_INH, S_TX_SHIFT, S_TX_ACK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    rx_sh_q, rx_sh_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic          clk_prev_q;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_err_q, tx_err_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;
  logic [7:0]    rx_data_q, rx_data_d;

  logic fall, rx_start, timed_out;

  assign fall      = clk_prev_q & ~ps2_clk_s;
  assign rx_start  = fall & ~ps2_data_s;
  assign timed_out = (cnt_q == TO_LAST);

  // A device start bit seen in the same cycle as a request wins the link.
  assign tx_ready = (state_q == S_IDLE) & ~rx_start;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    rx_data_d  = rx_data_q;

    unique case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        cnt_d     = '0;
        bit_d     = '0;
        if (rx_start) begin
          state_d = S_RX;
        end else if (tx_valid) begin
          // Frame after the start bit: data LSB first, odd parity, stop.
          tx_sh_d  = {1'b1, ~^tx_data, tx_data};
          clk_oe_d = 1'b1;
          state_d  = S_TX_INH;
        end
      end

      S_RX: begin
        if (fall) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            // Sample 10 is the stop bit; rx_sh_q holds data + parity.
            rx_data_d  = rx_sh_q[7:0];
            rx_valid_d = 1'b1;
            rx_err_d   = ~(^rx_sh_q) | ~ps2_data_s;
            state_d    = S_IDLE;
          end else begin
            rx_sh_d = {ps2_data_s, rx_sh_q[8:1]};
          end
        end else if (timed_out) begin
          rx_err_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_TX_INH: begin
        // Device falls are ignored here: we are holding the clock low ourselves.
        if (cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          cnt_d     = '0;
          bit_d     = '0;
          state_d   = S_TX_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_TX_SHIFT: begin
        if (fall) begin
          cnt_d     = '0;
          data_oe_d = ~tx_sh_q[0];
          tx_sh_d   = {1'b1, tx_sh_q[9:1]};
          bit_d     = bit_q + 4'd1;
          if (bit_q == 4'd9) state_d = S_TX_ACK;
        end else if (timed_out) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          tx_done_d = 1'b1;
          tx_err_d  = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_TX_ACK: begin
        if (fall) begin
          data_oe_d = 1'b0;
          tx_done_d = 1'b1;
          tx_err_d  = ps2_data_s;
          state_d   = S_IDLE;
        end else if (timed_out) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          tx_done_d = 1'b1;
          tx_err_d  = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      clk_prev_q <= 1'b1;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      clk_prev_q <= ps2_clk_s;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = tx_done_q;
  assign tx_err      = tx_err_q;
  assign rx_valid    = rx_valid_q;
  assign rx_err      = rx_err_q;
  assign rx_data     = rx_data_q;

endmodule
